// File: rtl/bf16_result_serializer.sv
// bf16_result_serializer: buffers BF16 words from the converter in a small FIFO
// and streams each one out as two bytes (MSB first) over a valid/ready byte port.
// The upstream has no backpressure, so a word that arrives while the FIFO is full
// is dropped and recorded in a sticky overflow flag.
module bf16_result_serializer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    input  logic [15:0]       in_data_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              overflow_o,
    input  logic              clr_ovf_i
);

    typedef enum logic [1:0] {IDLE, HI, LO} state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_t              state_q;
    logic [15:0]         mem_q [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]     count_q, count_d;
    logic                full_q, empty_q, ovf_q;
    logic [15:0]         sreg_q;
    logic [7:0]          tx_data_q;
    logic                tx_valid_q;
    logic                push, drop, pop;
    logic [15:0]         head;

    assign head = mem_q[rd_ptr_q];
    assign push = in_valid_i && !full_q;
    assign drop = in_valid_i && full_q;
    // The FSM takes the head word whenever it is idle, or when the low byte of
    // the current word is accepted (back-to-back transfer with no bubble).
    assign pop  = !empty_q && ((state_q == IDLE) || (state_q == LO && tx_ready_i));

    // Next occupancy; a push and pop on the same edge cancel out.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= in_data_i;
    end

    // FIFO pointers, registered occupancy flags and the sticky overflow flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_C);
            empty_q <= (count_d == '0);
            // A drop on the same edge as a clear leaves the flag set.
            if (drop)           ovf_q <= 1'b1;
            else if (clr_ovf_i) ovf_q <= 1'b0;
        end
    end

    // Byte serializer FSM: high byte, then low byte, with registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            sreg_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty_q) begin
                        sreg_q     <= head;
                        tx_data_q  <= head[15:8];
                        tx_valid_q <= 1'b1;
                        state_q    <= HI;
                    end
                end
                HI: begin
                    if (tx_ready_i) begin
                        tx_data_q <= sreg_q[7:0];
                        state_q   <= LO;
                    end
                end
                LO: begin
                    if (tx_ready_i) begin
                        if (!empty_q) begin
                            sreg_q    <= head;
                            tx_data_q <= head[15:8];
                            state_q   <= HI;
                        end else begin
                            tx_valid_q <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                end
                default: begin
                    tx_valid_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign count_o    = count_q;
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign overflow_o = ovf_q;

endmodule
